pim_conv_sched: RTL and testbench
=================================

# pim_conv_sched

Job sequencer for the PIM convolution crossbar (bram_pim behind conv). It accepts a convolution job: a base row address, a row count and a multi-bit activation vector. For each row it streams the activation bit-serially, MSB-first, into the crossbar, one bit-slice per compute strobe, and shift-add accumulates the ADC partial sums. It returns one accumulated dot product per row over a valid/ready stream, then pulses done.

## Interface
- CROSS_SIZE, 64, crossbar input ports (activation lanes)
- DEPTH, 6, crossbar row-address width
- ADC_P, 8, ADC result width
- IN_BITS, 8, activation precision (bit-slices per row)
- PIM_LAT, 1, cycles from compute strobe to valid ADC result (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  scheduler idle, can accept job
- job_base  in  DEPTH  first crossbar row
- job_count  in  DEPTH+1  rows to process (0..2^DEPTH)
- job_act  in  CROSS_SIZE*IN_BITS  activations; lane i = bits [i*IN_BITS +: IN_BITS]
- pim_en  out  1  compute strobe to crossbar
- pim_addr  out  DEPTH  crossbar row
- pim_data  out  CROSS_SIZE  current bit-slice (bit i = lane i activation bit b)
- pim_out  in  ADC_P  ADC result from crossbar
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  ADC_P+IN_BITS  accumulated row result (unsigned)
- res_row  out  DEPTH  row address of res_data
- done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: job_ready=1. On job_valid&&job_ready, latch base, count and act. Clear the accumulator and row counter; set bit index b=IN_BITS-1.
  - count=0 → pulse done next cycle, stay IDLE.
  - otherwise → ISSUE.
- ISSUE (1 cycle): pim_en=1, pim_addr=(base+row) mod 2^DEPTH (wraps), pim_data=slice b. → WAIT.
- WAIT: count PIM_LAT cycles. In the last one, sample pim_out and set acc=(acc<<1)+pim_out.
  - If b>0: decrement b → ISSUE.
  - Else → OUT.
- OUT: res_valid=1, res_data=acc, res_row=pim_addr of that row. Hold stable until res_ready.
  - On handshake with rows remaining: row++, acc=0, b=IN_BITS-1 → ISSUE.
  - On handshake with the last row: → IDLE with done=1 that cycle.
- Width: acc is ADC_P+IN_BITS bits, unsigned; max (2^ADC_P−1)(2^IN_BITS−1) fits, so no overflow or saturation.
- job_valid outside IDLE is ignored (job_ready=0). The job_* inputs are only sampled at acceptance.
- pim_out is ignored outside the sampling cycle.
- Reset (any time, including mid-job): state IDLE, job aborted, no done pulse. pim_en=0, pim_addr=0, pim_data=0, res_valid=0, res_data=0, res_row=0, done=0; job_ready=1 after release.

## Timing
- Job accepted at cycle 0 → first pim_en at cycle 1.
- Slice k strobes at 1+k(PIM_LAT+1); its result is sampled at cycle 1+k(PIM_LAT+1)+PIM_LAT.
- First res_valid at cycle IN_BITS(PIM_LAT+1)+1 (defaults: cycle 17).
- Next row's first pim_en is the cycle after the res handshake. Zero-stall row period is IN_BITS(PIM_LAT+1)+1.
- done coincides with the cycle after the last handshake edge (the IDLE entry cycle). job_ready=1 in the same cycle, so a back-to-back job may be accepted then.
- All outputs are registered.

## Configuration
- PIM_SCHED_PERF_EN defined: adds outputs perf_busy [31:0] and perf_stall [31:0].
  - perf_busy counts cycles not in IDLE.
  - perf_stall counts OUT cycles with res_ready=0.
  - Both cleared by reset and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package pim_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, OUT);
  - localparam ACC_W = ADC_P+IN_BITS;
  - the PIM_LAT counter width, $clog2(PIM_LAT+1).
- One natural sub-module, pim_shift_acc: clear, shift-add enable, ADC_P in, ACC_W out.
- FSM, address/bit counters and the activation register stay in the top.

## Test plan
- Bench crossbar model: pim_out = popcount(pim_data & W[pim_addr]), PIM_LAT-delayed.
- Single row: base=3, count=1, all lanes act=8'hFF, W[3]=all ones → res_data=64×255=16320, res_row=3, res_valid at cycle 17, done one cycle after handshake.
- Wrap: base=62, count=4 → res_row sequence 62, 63, 0, 1 with correct per-row sums.
- Backpressure: res_ready low 5 cycles in OUT → res_data/res_row stable, no pim_en until handshake; with PIM_SCHED_PERF_EN, perf_stall=5.
- count=0 → no pim_en, done pulses the cycle after acceptance, job_ready stays 1.
- Reset asserted mid-WAIT of row 2 → all outputs 0 immediately, no done. The next job runs correctly from its base.
- PIM_LAT=3, act lane0=8'h81, W lane0 only → res_data=129; pim_en period 4 cycles.

Source files
------------

// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared types, default widths and width helpers for the PIM convolution scheduler
package pim_pkg;

  // Scheduler phases: accept a job, strobe one bit-slice, wait for the ADC, present the row result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_state_e;

  localparam int ADC_P_DEF   = 8;
  localparam int IN_BITS_DEF = 8;
  localparam int PIM_LAT_DEF = 1;

  // Shift-add of IN_BITS slices of ADC_P-bit sums never exceeds ADC_P+IN_BITS bits
  localparam int ACC_W = ADC_P_DEF + IN_BITS_DEF;

  function automatic int acc_width(input int adc_p, input int in_bits);
    return adc_p + in_bits;
  endfunction

  // Width of the ADC latency counter, $clog2(PIM_LAT+1)
  function automatic int lat_width(input int pim_lat);
    return (pim_lat < 1) ? 1 : $clog2(pim_lat + 1);
  endfunction

endpackage

// File: rtl/pim_conv_sched_if.sv
// rtl/pim_conv_sched_if.sv - job, crossbar and result signal bundle for pim_conv_sched
interface pim_conv_sched_if #(
  parameter int CROSS_SIZE = 64,
  parameter int DEPTH      = 6,
  parameter int ADC_P      = 8,
  parameter int IN_BITS    = 8
);

  logic                          job_valid;
  logic                          job_ready;
  logic [DEPTH-1:0]              job_base;
  logic [DEPTH:0]                job_count;
  logic [CROSS_SIZE*IN_BITS-1:0] job_act;

  logic                          pim_en;
  logic [DEPTH-1:0]              pim_addr;
  logic [CROSS_SIZE-1:0]         pim_data;
  logic [ADC_P-1:0]              pim_out;

  logic                          res_valid;
  logic                          res_ready;
  logic [ADC_P+IN_BITS-1:0]      res_data;
  logic [DEPTH-1:0]              res_row;
  logic                          done;

  // Scheduler side
  modport master (
    input  job_valid, job_base, job_count, job_act, pim_out, res_ready,
    output job_ready, pim_en, pim_addr, pim_data, res_valid, res_data, res_row, done
  );

  // Job source, crossbar and result consumer side
  modport slave (
    output job_valid, job_base, job_count, job_act, pim_out, res_ready,
    input  job_ready, pim_en, pim_addr, pim_data, res_valid, res_data, res_row, done
  );

endinterface

// File: rtl/pim_shift_acc.sv
// rtl/pim_shift_acc.sv - MSB-first shift-add accumulator for bit-serial ADC partial sums
module pim_shift_acc
  import pim_pkg::*;
#(
  parameter int ADC_P = ADC_P_DEF,
  parameter int ACC_W = pim_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [ADC_P-1:0] din,
  output logic [ACC_W-1:0] acc
);

  // Each enabled cycle weights the running sum by 2 and adds the new slice's ADC result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= {acc[ACC_W-2:0], 1'b0} + ACC_W'(din);
    end
  end

endmodule

// File: rtl/pim_conv_sched.sv
// rtl/pim_conv_sched.sv - PIM convolution job sequencer; optional perf counters under PIM_SCHED_PERF_EN
module pim_conv_sched
  import pim_pkg::*;
#(
  parameter int CROSS_SIZE = 64,
  parameter int DEPTH      = 6,
  parameter int ADC_P      = ADC_P_DEF,
  parameter int IN_BITS    = IN_BITS_DEF,
  parameter int PIM_LAT    = PIM_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pim_conv_sched_if.master bus
`ifdef PIM_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_busy,
  output logic [31:0]      perf_stall
`endif
);

  localparam int AW = acc_width(ADC_P, IN_BITS);
  localparam int LW = lat_width(PIM_LAT);
  localparam int BW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [BW-1:0] BIT_TOP  = BW'(IN_BITS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(PIM_LAT - 1);

  sched_state_e                  state, state_n;
  logic [DEPTH-1:0]              base_q;
  logic [DEPTH:0]                count_q, row_q, row_n;
  logic [CROSS_SIZE*IN_BITS-1:0] act_q, act_src;
  logic [BW-1:0]                 bit_q, bit_n;
  logic [LW-1:0]                 lat_q, lat_n;
  logic                          accept, acc_clr, acc_en, done_n;
  logic [DEPTH-1:0]              addr_n;
  logic [CROSS_SIZE-1:0]         slice_n;
  logic [AW-1:0]                 acc;

  logic                          job_ready_q, pim_en_q, res_valid_q, done_q;
  logic [DEPTH-1:0]              pim_addr_q, res_row_q;
  logic [CROSS_SIZE-1:0]         pim_data_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state, counter updates and accumulator controls
  always_comb begin
    state_n = state;
    row_n   = row_q;
    bit_n   = bit_q;
    lat_n   = lat_q;
    accept  = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          accept  = 1'b1;
          acc_clr = 1'b1;
          row_n   = '0;
          bit_n   = BIT_TOP;
          if (bus.job_count == '0) done_n  = 1'b1;
          else                     state_n = ISSUE;
        end
      end
      ISSUE: begin
        lat_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          acc_en = 1'b1;
          if (bit_q != '0) begin
            bit_n   = bit_q - 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = OUT;
          end
        end else begin
          lat_n = lat_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          if ((row_q + (DEPTH+1)'(1)) == count_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            row_n   = row_q + (DEPTH+1)'(1);
            bit_n   = BIT_TOP;
            acc_clr = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Row address and bit-slice for the next strobe; on acceptance they come straight from the job inputs
  always_comb begin
    act_src = accept ? bus.job_act : act_q;
    addr_n  = (accept ? bus.job_base : base_q) + row_n[DEPTH-1:0];
    slice_n = '0;
    for (int i = 0; i < CROSS_SIZE; i++) begin
      slice_n[i] = act_src[i*IN_BITS + int'(bit_n)];
    end
  end

  // Job latch and row/bit/latency counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      count_q <= '0;
      act_q   <= '0;
      row_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
    end else begin
      if (accept) begin
        base_q  <= bus.job_base;
        count_q <= bus.job_count;
        act_q   <= bus.job_act;
      end
      row_q <= row_n;
      bit_q <= bit_n;
      lat_q <= lat_n;
    end
  end

  // Registered outputs; pim_addr/pim_data hold the current row's values between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job_ready_q <= 1'b1;
      pim_en_q    <= 1'b0;
      pim_addr_q  <= '0;
      pim_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      job_ready_q <= (state_n == IDLE);
      pim_en_q    <= (state_n == ISSUE);
      res_valid_q <= (state_n == OUT);
      done_q      <= done_n;
      if (state_n == ISSUE) begin
        pim_addr_q <= addr_n;
        pim_data_q <= slice_n;
      end
      if (state == WAIT && state_n == OUT) begin
        res_row_q <= pim_addr_q;
      end
    end
  end

  pim_shift_acc #(
    .ADC_P (ADC_P),
    .ACC_W (AW)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clr),
    .en    (acc_en),
    .din   (bus.pim_out),
    .acc   (acc)
  );

  assign bus.job_ready = job_ready_q;
  assign bus.pim_en    = pim_en_q;
  assign bus.pim_addr  = pim_addr_q;
  assign bus.pim_data  = pim_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc;
  assign bus.res_row   = res_row_q;
  assign bus.done      = done_q;

`ifdef PIM_SCHED_PERF_EN
  // Saturating activity counters: busy = any non-IDLE cycle, stall = result held by the consumer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (state != IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
      if (state == OUT && !bus.res_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pim_conv_sched.sv
// tb/tb_pim_conv_sched.sv - randomized self-checking bench for pim_conv_sched against a dot-product model
module tb_pim_conv_sched;

  localparam int CS   = 64;
  localparam int DP   = 6;
  localparam int AP   = 8;
  localparam int IB   = 8;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int AW   = pim_pkg::ACC_W;
  localparam int ROW_CYC = IB * (LAT + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pim_conv_sched_if #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(AP), .IN_BITS(IB)) bus ();
  pim_conv_sched_if #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(AP), .IN_BITS(IB)) bus3 ();

`ifdef PIM_SCHED_PERF_EN
  logic [31:0] perf_busy, perf_stall, perf_busy3, perf_stall3;
`endif

  pim_conv_sched #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(AP), .IN_BITS(IB), .PIM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
`ifdef PIM_SCHED_PERF_EN
    ,
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall)
`endif
  );

  pim_conv_sched #(.CROSS_SIZE(CS), .DEPTH(DP), .ADC_P(AP), .IN_BITS(IB), .PIM_LAT(LAT3)) dut3 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus3)
`ifdef PIM_SCHED_PERF_EN
    ,
    .perf_busy  (perf_busy3),
    .perf_stall (perf_stall3)
`endif
  );

  // Crossbar models: popcount of the strobed slice against the addressed weight row, delayed PIM_LAT cycles;
  // random values appear on pim_out whenever no result is due
  logic [CS-1:0] w  [0:(1<<DP)-1];
  logic [CS-1:0] w3 [0:(1<<DP)-1];
  logic [AP-1:0] pipe  [0:LAT-1];
  logic [AP-1:0] pipe3 [0:LAT3-1];

  function automatic logic [AP-1:0] xbar(input logic [CS-1:0] d, input logic [CS-1:0] wr);
    return AP'($countones(d & wr));
  endfunction

  always @(posedge clk) begin
    pipe[0] <= bus.pim_en ? xbar(bus.pim_data, w[bus.pim_addr]) : AP'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.pim_out = pipe[LAT-1];

  always @(posedge clk) begin
    pipe3[0] <= bus3.pim_en ? xbar(bus3.pim_data, w3[bus3.pim_addr]) : AP'($urandom);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign bus3.pim_out = pipe3[LAT3-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Row result = sum over lanes whose weight bit is set of that lane's activation value
  function automatic logic [AW-1:0] dot(input logic [CS*IB-1:0] act, input logic [CS-1:0] wr);
    int s = 0;
    for (int i = 0; i < CS; i++) if (wr[i]) s += int'(act[i*IB +: IB]);
    return AW'(s);
  endfunction

  function automatic logic [CS*IB-1:0] rand_act();
    logic [CS*IB-1:0] v;
    for (int i = 0; i < CS*IB/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // mode 0: always ready, 1: random ready, 2: hold the first result for 5 cycles
  task automatic run_job(input logic [DP-1:0] base, input logic [DP:0] cnt,
                         input logic [CS*IB-1:0] act, input int mode);
    logic [AW-1:0] exp_q [$];
    logic [DP-1:0] row_q [$];
    logic [CS-1:0] sl;
    int t, hs, strobes, first_en, first_rv, last_hs_t, budget, stall_left;
    bit finished, ready;
    for (int r = 0; r < int'(cnt); r++) begin
      row_q.push_back(DP'(int'(base) + r));
      exp_q.push_back(dot(act, w[DP'(int'(base) + r)]));
    end
    @(negedge clk);
    check("job_ready_idle", bus.job_ready, 1);
    bus.job_valid = 1'b1;
    bus.job_base  = base;
    bus.job_count = cnt;
    bus.job_act   = act;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.job_valid = (cnt != 0);
    bus.job_base  = DP'($urandom);
    bus.job_count = (DP+1)'($urandom);
    bus.job_act   = rand_act();
    t = 1; hs = 0; strobes = 0; first_en = -1; first_rv = -1; last_hs_t = -10;
    stall_left = (mode == 2) ? 5 : 0;
    finished = 1'b0;
    budget = int'(cnt) * ROW_CYC * 4 + 50;
    while (!finished && t < budget) begin
      if (cnt == 0) begin
        check("zero_done", bus.done, 1);
        check("zero_ready", bus.job_ready, 1);
        check("zero_no_en", bus.pim_en, 0);
        finished = 1'b1;
      end else if (hs == int'(cnt) && t == last_hs_t + 1) begin
        check("done", bus.done, 1);
        check("done_ready", bus.job_ready, 1);
        check("done_no_en", bus.pim_en, 0);
        finished = 1'b1;
      end else begin
        check("done_low", bus.done, 0);
        if (bus.pim_en) begin
          if (first_en < 0) first_en = t;
          if (hs < int'(cnt)) begin
            check("pim_addr", bus.pim_addr, row_q[hs]);
            for (int i = 0; i < CS; i++) sl[i] = act[i*IB + (IB - 1 - strobes % IB)];
            check("pim_data", bus.pim_data, sl);
            if (hs > 0 && strobes % IB == 0) check("row_restart", t, last_hs_t + 1);
          end else begin
            check("en_extra", hs, int'(cnt) - 1);
          end
          strobes++;
        end
        if (bus.res_valid) begin
          if (first_rv < 0) first_rv = t;
          check("no_en_in_out", bus.pim_en, 0);
          if (hs < int'(cnt)) begin
            check("res_data", bus.res_data, exp_q[hs]);
            check("res_row", bus.res_row, row_q[hs]);
          end else begin
            check("res_extra", hs, int'(cnt) - 1);
          end
          if (mode == 1) ready = 1'($urandom_range(0, 1));
          else if (stall_left > 0) begin ready = 1'b0; stall_left--; end
          else ready = 1'b1;
          bus.res_ready = ready;
          if (ready) begin
            hs++;
            last_hs_t = t;
            if (hs == int'(cnt)) bus.job_valid = 1'b0;
          end
        end else begin
          bus.res_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        t++;
      end
    end
    bus.res_ready = 1'b0;
    bus.job_valid = 1'b0;
    check("job_finished", finished, 1);
    if (cnt != 0) begin
      check("first_en_cycle", first_en, 1);
      check("first_rv_cycle", first_rv, ROW_CYC);
      check("strobe_count", strobes, int'(cnt) * IB);
      check("result_count", hs, int'(cnt));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [CS*IB-1:0] a;
    int n, t;
    int en_t [$];
    bit got;
    bus.job_valid = 0;  bus.job_base = 0;  bus.job_count = 0;  bus.job_act = 0;  bus.res_ready = 0;
    bus3.job_valid = 0; bus3.job_base = 0; bus3.job_count = 0; bus3.job_act = 0; bus3.res_ready = 0;
    for (int r = 0; r < (1 << DP); r++) begin
      w[r]  = {$urandom, $urandom};
      w3[r] = 64'd1;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pim_en", bus.pim_en, 0);
    check("rst_pim_addr", bus.pim_addr, 0);
    check("rst_pim_data", bus.pim_data, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_row", bus.res_row, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_job_ready", bus.job_ready, 1);

    // Single row, all ones: 64 x 255
    w[3] = '1;
    a = '1;
    run_job(6'd3, 7'd1, a, 0);
    // Address wrap 62, 63, 0, 1
    run_job(6'd62, 7'd4, rand_act(), 0);
    // Backpressure on the first result
    run_job(6'd20, 7'd2, rand_act(), 2);
`ifdef PIM_SCHED_PERF_EN
    check("perf_stall", perf_stall, 5);
    check("perf_busy", perf_busy, 7 * ROW_CYC + 5);
`endif
    for (int j = 0; j < 6; j++) begin
      run_job(DP'($urandom), (DP+1)'($urandom_range(1, 8)), rand_act(), 1);
    end
    run_job(DP'($urandom), 7'd64, rand_act(), 0);
    run_job(6'd10, 7'd0, rand_act(), 0);

    // Reset during the WAIT of row index 2
    @(negedge clk);
    bus.job_valid = 1'b1; bus.job_base = 6'd50; bus.job_count = 7'd4;
    bus.job_act = rand_act(); bus.res_ready = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    n = 0; t = 0;
    while (n < 2 && t < 200) begin
      if (bus.res_valid) n++;
      @(negedge clk);
      t++;
    end
    while (!bus.pim_en && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("abort_row2_reached", n, 2);
    rst_n = 1'b0;
    #1;
    check("abort_pim_en", bus.pim_en, 0);
    check("abort_pim_addr", bus.pim_addr, 0);
    check("abort_pim_data", bus.pim_data, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_res_data", bus.res_data, 0);
    check("abort_res_row", bus.res_row, 0);
    check("abort_done", bus.done, 0);
    bus.res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_idle_done", bus.done, 0);
      check("abort_job_ready", bus.job_ready, 1);
    end
    run_job(6'd40, 7'd3, rand_act(), 1);

    // PIM_LAT=3 instance: lane 0 only, activation 8'h81
    a = rand_act();
    a[IB-1:0] = 8'h81;
    @(negedge clk);
    bus3.job_valid = 1'b1; bus3.job_base = 6'd5; bus3.job_count = 7'd1;
    bus3.job_act = a; bus3.res_ready = 1'b1;
    @(negedge clk);
    bus3.job_valid = 1'b0;
    t = 1; got = 1'b0;
    while (!got && t < 100) begin
      if (bus3.pim_en) en_t.push_back(t);
      if (bus3.res_valid) begin
        check("lat3_res_data", bus3.res_data, 129);
        check("lat3_res_row", bus3.res_row, 5);
        check("lat3_first_rv", t, IB * (LAT3 + 1) + 1);
        got = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    check("lat3_result_seen", got, 1);
    check("lat3_done", bus3.done, 1);
    check("lat3_strobes", en_t.size(), IB);
    foreach (en_t[k]) check("lat3_en_cycle", en_t[k], 1 + k * (LAT3 + 1));
`ifdef PIM_SCHED_PERF_EN
    check("lat3_perf_busy", perf_busy3, IB * (LAT3 + 1) + 1);
    check("lat3_perf_stall", perf_stall3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
